wb_stage_reg: RTL
=================

Name: wb_stage_reg

Overview:
- Parametrised, registered write-back stage for the RV32I pipeline; generalises the combinational write-back mux.
- Selects among four result sources and performs load data alignment with sign/zero extension.
- Registers the register-file write port with stall/flush control and counts retired instructions.
- Sits between the memory-access stage and the register file; its registered output also feeds the forwarding unit.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 64, width of the retired-instruction counter.
- REG_AW, 5, register address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  MA stage holds a valid instruction.
- i_stall  in  1  hold WB register contents; do not capture.
- i_flush  in  1  invalidate the WB register.
- i_wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- i_reg_write  in  1  instruction writes rd.
- i_rd  in  REG_AW  destination register.
- i_funct3  in  3  load size/sign; used only when i_wb_sel=01.
- i_addr_lo  in  log2(XLEN/8)  low bits of the load address.
- i_result  in  XLEN  ALU result.
- i_read_data  in  XLEN  raw aligned memory word.
- i_pc_plus_4  in  XLEN  return address for JAL/JALR.
- i_imm  in  XLEN  immediate for LUI.
- o_rf_we  out  1  register-file write enable.
- o_rf_waddr  out  REG_AW  register-file write address.
- o_rf_wdata  out  XLEN  register-file write data.
- o_retire  out  1  one instruction retired this cycle.
- o_instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: all outputs are 0 on the first rising edge with i_rst=1. Reset overrides flush, stall and capture, including in the middle of a stall.
- Load extraction is combinational and happens before the register. The byte lane is i_addr_lo. Halfword uses i_addr_lo with bit 0 ignored. Word on XLEN=32 ignores i_addr_lo.
  - funct3 000 LB: sign-extend the selected byte.
  - funct3 100 LBU: zero-extend the selected byte.
  - funct3 001 LH: sign-extend the selected halfword.
  - funct3 101 LHU: zero-extend the selected halfword.
  - funct3 010 LW: the word; sign-extended when XLEN=64 (half selected by i_addr_lo[2]).
  - funct3 110 LWU: zero-extended word; XLEN=64 only.
  - funct3 011 LD: the full doubleword; XLEN=64 only.
  - Any other funct3 value (or an XLEN=64-only code on XLEN=32): load data = 0.
- Selected data goes through a 4:1 mux driven by i_wb_sel.
- Capture on a rising edge, no reset, priority order:
  - i_flush=1: o_rf_we=0, o_retire=0. Address and data are don't-care but are held at their previous values. Flush wins over stall.
  - else i_stall=1: all outputs hold, and o_retire is forced to 0 so a held instruction is not counted twice.
  - else: o_rf_we <= i_valid & i_reg_write & (i_rd!=0); o_rf_waddr <= i_rd; o_rf_wdata <= selected data; o_retire <= i_valid.
- Latency: exactly one cycle from input to register-file port.
- x0 handling: o_rf_we is never 1 with o_rf_waddr=0. The instruction still retires (o_retire=1).
- o_instret:
  - Increments by 1 on the cycle after o_retire=1; it counts registered o_retire.
  - Wraps modulo 2^CNT_W with no saturation.
  - Resets to 0 and is not affected by flush.
- Stall during a stall: o_rf_we stays as captured. The register file is written again each held cycle, which is idempotent.

Test Plan:
- Reset, then valid ALU op: i_wb_sel=00, i_rd=5, i_result=0x1234 -> next cycle o_rf_we=1, o_rf_waddr=5, o_rf_wdata=0x1234, o_retire=1; one cycle later o_instret=1.
- Loads on i_read_data=0x80FF7F01:
  - LB, addr_lo=3 -> 0xFFFFFF80.
  - LBU, addr_lo=1 -> 0x0000007F.
  - LH, addr_lo=2 -> 0xFFFF80FF.
  - LHU, addr_lo=0 -> 0x00007F01.
  - funct3=011 on XLEN=32 -> 0.
- JAL: i_wb_sel=10, i_pc_plus_4=0x104, i_rd=1 -> o_rf_wdata=0x104. LUI: i_wb_sel=11, i_imm=0xABCDE000 -> o_rf_wdata=0xABCDE000.
- Write to x0 with i_reg_write=1 -> o_rf_we=0, o_retire=1, o_instret increments.
- Stall then flush:
  - Capture rd=7; assert i_stall 3 cycles -> outputs held, o_retire=0, o_instret unchanged.
  - i_stall=1 with i_flush=1 -> o_rf_we=0.
  - i_rst mid-stall -> all outputs 0.
- Counter wrap with CNT_W=4: 16 retirements -> o_instret returns to 0. XLEN=64: LD returns all 64 bits; LW of 0x80000000 -> 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/wb_stage_reg.sv
// Registered RV32I/RV64I write-back stage: load alignment/extension, 4:1 result select,
// register-file write port with stall/flush, and a retired-instruction counter.
module wb_stage_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CNT_W  = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [1:0]                i_wb_sel,
    input  logic                      i_reg_write,
    input  logic [REG_AW-1:0]         i_rd,
    input  logic [2:0]                i_funct3,
    input  logic [$clog2(XLEN/8)-1:0] i_addr_lo,
    input  logic [XLEN-1:0]           i_result,
    input  logic [XLEN-1:0]           i_read_data,
    input  logic [XLEN-1:0]           i_pc_plus_4,
    input  logic [XLEN-1:0]           i_imm,
    output logic                      o_rf_we,
    output logic [REG_AW-1:0]         o_rf_waddr,
    output logic [XLEN-1:0]           o_rf_wdata,
    output logic                      o_retire,
    output logic [CNT_W-1:0]          o_instret
);

    localparam int unsigned AW = $clog2(XLEN/8);

    logic [XLEN-1:0]   byte_sh, half_sh, word_sh;
    logic [7:0]        lb;
    logic [15:0]       lh;
    logic [31:0]       lw;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   wb_data;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    // Lanes are pulled down to bit 0 by shifting; the word half only matters on XLEN=64.
    always_comb begin
        byte_sh   = i_read_data >> {i_addr_lo, 3'b000};
        half_sh   = i_read_data >> {i_addr_lo[AW-1:1], 4'b0000};
        word_sh   = (XLEN == 64 && i_addr_lo[AW-1]) ? (i_read_data >> 32) : i_read_data;
        lb        = byte_sh[7:0];
        lh        = half_sh[15:0];
        lw        = word_sh[31:0];
        load_data = '0;
        case (i_funct3)
            3'b000:  load_data = XLEN'($signed(lb));
            3'b100:  load_data = XLEN'(lb);
            3'b001:  load_data = XLEN'($signed(lh));
            3'b101:  load_data = XLEN'(lh);
            3'b010:  load_data = XLEN'($signed(lw));
            3'b110:  if (XLEN == 64) load_data = XLEN'(lw);
            3'b011:  if (XLEN == 64) load_data = i_read_data;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        case (i_wb_sel)
            2'b00:   wb_data = i_result;
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = i_pc_plus_4;
            default: wb_data = i_imm;
        endcase
    end

    always_comb begin
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        retire_d   = 1'b0;
        if (i_flush) begin
            rf_we_d = 1'b0;
        end else if (!i_stall) begin
            rf_we_d    = i_valid & i_reg_write & (i_rd != '0);
            rf_waddr_d = i_rd;
            rf_wdata_d = wb_data;
            retire_d   = i_valid;
        end
        instret_d = instret_q + CNT_W'(retire_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retire_q   <= 1'b0;
            instret_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retire_q   <= retire_d;
            instret_q  <= instret_d;
        end
    end

    assign o_rf_we    = rf_we_q;
    assign o_rf_waddr = rf_waddr_q;
    assign o_rf_wdata = rf_wdata_q;
    assign o_retire   = retire_q;
    assign o_instret  = instret_q;

endmodule
